// File: rtl/trace_nop_event_extractor_if.sv
// Trace-in / event-out bus bundle for trace_nop_event_extractor.
//   trace_* : one retired-instruction trace entry per cycle (producer -> extractor)
//   ev_*    : head of the event FIFO with a valid/ready handshake (extractor -> consumer)
// master: the side that drives trace entries and consumes events (testbench / trace source).
// slave:  the extractor itself.
interface trace_nop_event_extractor_if;
  logic        trace_valid;
  logic [31:0] trace_insn;
  logic [31:0] trace_pc;
  logic        trace_wben;
  logic [4:0]  trace_wbreg;
  logic [31:0] trace_wbdata;

  logic        ev_valid;
  logic        ev_ready;
  logic [15:0] ev_code;
  logic [31:0] ev_value;
  logic [31:0] ev_pc;
  logic [15:0] ev_core;

  modport master (
    output trace_valid, trace_insn, trace_pc, trace_wben, trace_wbreg, trace_wbdata,
    output ev_ready,
    input  ev_valid, ev_code, ev_value, ev_pc, ev_core
  );

  modport slave (
    input  trace_valid, trace_insn, trace_pc, trace_wben, trace_wbreg, trace_wbdata,
    input  ev_ready,
    output ev_valid, ev_code, ev_value, ev_pc, ev_core
  );
endinterface

// File: rtl/trace_nop_event_extractor.sv
// Per-core trace consumer: keeps a shadow copy of r3 from trace writebacks and turns
// simulation-control "l.nop K" (K != 0) instructions into {code, r3, pc} events held in a
// small FIFO. An exit nop (K == 1) is enqueued and then blocks all later events.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : trace input and event output handshake (slave side)
//   r3          : shadow r3
//   overflow    : sticky, an event was dropped because the FIFO was full
//   drop_count  : saturating count of dropped events
//   terminated  : sticky, an exit nop has been captured
module trace_nop_event_extractor #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] CORE_ID    = 16'd0
) (
  input  logic                          clk,
  input  logic                          rst,
  trace_nop_event_extractor_if.slave    bus,
  output logic [31:0]                   r3,
  output logic                          overflow,
  output logic [7:0]                    drop_count,
  output logic                          terminated
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     r3_q, r3_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_count_q, drop_count_d;
  logic            terminated_q, terminated_d;

  logic [15:0]     code_mem  [FIFO_DEPTH];
  logic [31:0]     value_mem [FIFO_DEPTH];
  logic [31:0]     pc_mem    [FIFO_DEPTH];

  logic            nop_match, push_req, push, pop, drop, empty, full;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign nop_match = bus.trace_valid && (bus.trace_insn[31:16] == 16'h1500) &&
                     (bus.trace_insn[15:0] != 16'h0000);
  assign push_req  = nop_match && !terminated_q;

  // ev_valid comes only from the pointers, so pop never loops back into it.
  assign pop  = !empty && bus.ev_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    r3_d         = r3_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    terminated_d = terminated_q;

    if (bus.trace_valid && bus.trace_wben && (bus.trace_wbreg == 5'd3)) begin
      r3_d = bus.trace_wbdata;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (bus.trace_insn[15:0] == 16'h0001) begin
        terminated_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hff) begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      r3_q         <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      terminated_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      r3_q         <= r3_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      terminated_q <= terminated_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  // The stored value is r3 before any writeback in the same cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      code_mem[wr_ptr_q[PtrW-1:0]]  <= bus.trace_insn[15:0];
      value_mem[wr_ptr_q[PtrW-1:0]] <= r3_q;
      pc_mem[wr_ptr_q[PtrW-1:0]]    <= bus.trace_pc;
    end
  end

  assign bus.ev_valid = !empty;
  assign bus.ev_code  = code_mem[rd_ptr_q[PtrW-1:0]];
  assign bus.ev_value = value_mem[rd_ptr_q[PtrW-1:0]];
  assign bus.ev_pc    = pc_mem[rd_ptr_q[PtrW-1:0]];
  assign bus.ev_core  = CORE_ID;

  assign r3         = r3_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign terminated = terminated_q;

endmodule

// File: tb/tb_trace_nop_event_extractor.sv
module tb_trace_nop_event_extractor;
  localparam int unsigned Depth = 4;
  localparam logic [15:0] CoreId = 16'h00a5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] r3;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        terminated;

  trace_nop_event_extractor_if bus();

  trace_nop_event_extractor #(
    .FIFO_DEPTH (Depth),
    .CORE_ID    (CoreId)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .r3         (r3),
    .overflow   (overflow),
    .drop_count (drop_count),
    .terminated (terminated)
  );

  always #5 clk = ~clk;

  // Reference model: event queue plus sticky status, stepped per clock edge.
  typedef struct {
    logic [15:0] code;
    logic [31:0] value;
    logic [31:0] pc;
  } ev_t;

  ev_t         m_q[$];
  logic [31:0] m_r3;
  logic        m_ovf;
  int          m_drops;
  logic        m_term;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_r3    = '0;
    m_ovf   = 1'b0;
    m_drops = 0;
    m_term  = 1'b0;
  endtask

  task automatic model_step();
    bit   is_nop;
    bit   popped;
    ev_t  e;
    is_nop = bus.trace_valid && bus.trace_insn[31:16] == 16'h1500 && bus.trace_insn[15:0] != 0;
    popped = (m_q.size() != 0) && bus.ev_ready;
    if (popped) void'(m_q.pop_front());
    if (is_nop && !m_term) begin
      if (m_q.size() < Depth) begin
        e.code  = bus.trace_insn[15:0];
        e.value = m_r3;
        e.pc    = bus.trace_pc;
        m_q.push_back(e);
        if (e.code == 16'd1) m_term = 1'b1;
      end else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    if (bus.trace_valid && bus.trace_wben && bus.trace_wbreg == 5'd3) m_r3 = bus.trace_wbdata;
  endtask

  task automatic compare_all();
    check("ev_valid", {31'd0, bus.ev_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0 && bus.ev_valid) begin
      check("ev_code", {16'd0, bus.ev_code}, {16'd0, m_q[0].code});
      check("ev_value", bus.ev_value, m_q[0].value);
      check("ev_pc", bus.ev_pc, m_q[0].pc);
      check("ev_core", {16'd0, bus.ev_core}, {16'd0, CoreId});
    end
    check("r3", r3, m_r3);
    check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check("drop_count", {24'd0, drop_count}, m_drops);
    check("terminated", {31'd0, terminated}, {31'd0, m_term});
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                       input logic wben, input logic [4:0] wbreg, input logic [31:0] wbdata,
                       input logic ready);
    bus.trace_valid  = v;
    bus.trace_insn   = insn;
    bus.trace_pc     = pc;
    bus.trace_wben   = wben;
    bus.trace_wbreg  = wbreg;
    bus.trace_wbdata = wbdata;
    bus.ev_ready     = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input logic ready);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, ready);
  endtask

  task automatic nop(input logic [15:0] k, input logic [31:0] pc, input logic ready);
    drive(1'b1, {16'h1500, k}, pc, 1'b0, 5'd0, 32'h0, ready);
  endtask

  task automatic wb(input logic [4:0] reg_idx, input logic [31:0] data, input logic ready);
    drive(1'b1, 32'he0000004, 32'h200, 1'b1, reg_idx, data, ready);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] insn;
    logic [15:0] k;
    idle(1'b0);
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Report path
    wb(5'd3, 32'hdeadbeef, 1'b0); tick();
    nop(16'h0002, 32'h100, 1'b0); tick();
    check("report_code", {16'd0, bus.ev_code}, 32'd2);
    check("report_value", bus.ev_value, 32'hdeadbeef);
    check("report_pc", bus.ev_pc, 32'h100);
    idle(1'b0); tick();
    idle(1'b1); tick();
    check("report_popped", {31'd0, bus.ev_valid}, 32'd0);

    // Ordering and non-events
    wb(5'd3, 32'd5, 1'b0); tick();
    nop(16'h0004, 32'h104, 1'b0); tick();
    check("order_value", bus.ev_value, 32'd5);
    idle(1'b1); tick();
    nop(16'h0000, 32'h108, 1'b0); tick();
    drive(1'b1, 32'h12345678, 32'h10c, 1'b0, 5'd0, 32'h0, 1'b0); tick();
    wb(5'd4, 32'h77, 1'b0); tick();
    drive(1'b0, 32'h15000003, 32'h110, 1'b1, 5'd3, 32'h99, 1'b0); tick();
    check("no_event", {31'd0, bus.ev_valid}, 32'd0);
    check("r3_kept", r3, 32'd5);

    // Overflow: six pushes into four slots
    for (int i = 0; i < 6; i++) begin
      nop(16'h0002, 32'h300 + 32'(i * 4), 1'b0); tick();
    end
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_drops", {24'd0, drop_count}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", bus.ev_pc, 32'h300 + 32'(i * 4));
      idle(1'b1); tick();
    end
    check("drain_empty", {31'd0, bus.ev_valid}, 32'd0);

    // Full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      nop(16'h0003, 32'h400 + 32'(i * 4), 1'b0); tick();
    end
    nop(16'h0003, 32'h410, 1'b1); tick();
    check("fullpop_drops", {24'd0, drop_count}, 32'd2);
    check("fullpop_head", bus.ev_pc, 32'h404);

    // Reset mid-stream with events queued
    idle(1'b0); tick();
    @(negedge clk);
    pulse_reset();
    check("rst_valid", {31'd0, bus.ev_valid}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    nop(16'h0007, 32'h500, 1'b0); tick();
    idle(1'b1); tick();
    check("post_rst_single", {31'd0, bus.ev_valid}, 32'd0);

    // Exit
    nop(16'h0001, 32'h600, 1'b0); tick();
    check("exit_term", {31'd0, terminated}, 32'd1);
    check("exit_code", {16'd0, bus.ev_code}, 32'd1);
    nop(16'h0002, 32'h604, 1'b1); tick();
    check("exit_blocked", {31'd0, bus.ev_valid}, 32'd0);
    wb(5'd3, 32'hcafe0001, 1'b0); tick();
    check("exit_r3", r3, 32'hcafe0001);

    // Randomized traffic with periodic resets to clear termination
    @(negedge clk);
    pulse_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 399) begin
        @(negedge clk);
        pulse_reset();
      end
      if ($urandom_range(0, 9) < 5) begin
        if ($urandom_range(0, 39) == 0) k = 16'd1;
        else if ($urandom_range(0, 3) == 0) k = 16'd0;
        else k = 16'($urandom_range(2, 65535));
        insn = {16'h1500, k};
      end else begin
        insn = $urandom;
      end
      drive($urandom_range(0, 9) < 8, insn, $urandom, 1'($urandom), 5'($urandom_range(0, 5)),
            $urandom, $urandom_range(0, 2) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
